// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Arbitrates framebuffer writes between two requesters (game logic on port 0,
// overlay on port 1) and a full-frame fill engine. Round-robin grants in IDLE,
// sequential fill of every cell in CLEAR, one registered write port.
//
// Optional build macro: FB_VBLANK_GATE_EN
//   defined   -> writes (grants and fill steps) are allowed only while vblank
//                is high; a fill pauses and holds its address while vblank is
//                low and resumes at that address when vblank rises.
//   undefined -> vblank is ignored and a write may be issued every cycle.

module fb_write_arbiter #(
    parameter int FB_DEPTH = 19200,
    parameter int ADDR_W   = 16
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              vblank,
    input  logic              valid0,
    input  logic              valid1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [2:0]        data0,
    input  logic [2:0]        data1,
    output logic              ready0,
    output logic              ready1,
    input  logic              clear_start,
    input  logic [2:0]        clear_code,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] wmemaddr,
    output logic [2:0]        wmemdata,
    output logic              wmemwe
);

    // FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Depth widened by one bit so the range test also works when FB_DEPTH
    // equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state_r;
    logic              busy_r;
    logic [ADDR_W-1:0] fill_cnt_r;
    logic [2:0]        fill_code_r;
    logic              prio_r;          // 0: requester 0 favoured, 1: requester 1
    logic [ADDR_W-1:0] wmemaddr_r;
    logic [2:0]        wmemdata_r;
    logic              wmemwe_r;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              allow_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              start_s;
    logic              accept_s;
    logic              fill_step_s;
    logic              fill_last_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [2:0]        sel_data_s;
    logic              in_range_s;

`ifdef FB_VBLANK_GATE_EN
    // Memory may only be touched outside active video rows.
    assign allow_s = vblank;
`else
    // Writes are unrestricted; vblank is deliberately left unused.
    logic vblank_unused_s;
    assign vblank_unused_s = vblank;
    assign allow_s         = 1'b1;
`endif

    // A fill request in IDLE takes precedence over any pending requester.
    assign start_s = (state_r == ST_IDLE) && clear_start && !clr;

    // Round-robin grant: at most one ready, none during reset, fill or gating.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (!clr && (state_r == ST_IDLE) && allow_s && !clear_start) begin
            if (valid0 && valid1) begin
                if (prio_r == 1'b0) begin
                    ready0_s = 1'b1;
                end else begin
                    ready1_s = 1'b1;
                end
            end else if (valid0) begin
                ready0_s = 1'b1;
            end else if (valid1) begin
                ready1_s = 1'b1;
            end else begin
                ready0_s = 1'b0;
                ready1_s = 1'b0;
            end
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign ready0 = ready0_s;
    assign ready1 = ready1_s;

    // Route the granted requester onto the write path.
    always_comb begin
        sel_addr_s = addr0;
        sel_data_s = data0;
        if (ready1_s) begin
            sel_addr_s = addr1;
            sel_data_s = data1;
        end else begin
            sel_addr_s = addr0;
            sel_data_s = data0;
        end
    end

    // Out-of-range requests are still accepted, they just never reach memory.
    assign in_range_s  = ({1'b0, sel_addr_s} < DEPTH_EXT);
    assign accept_s    = ready0_s || ready1_s;
    assign fill_step_s = (state_r == ST_CLEAR) && allow_s;
    assign fill_last_s = (fill_cnt_r == LAST_ADDR);

    // ------------------------------------------------------------------
    // Control: FSM, fill counter, latched fill colour, priority pointer
    // ------------------------------------------------------------------

    // Sequence IDLE/CLEAR, advance the fill and rotate requester priority.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            fill_cnt_r  <= ADDR_ZERO;
            fill_code_r <= 3'd0;
            prio_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        fill_code_r <= clear_code;
                        fill_cnt_r  <= ADDR_ZERO;
                        state_r     <= ST_CLEAR;
                        busy_r      <= 1'b1;
                    end else if (accept_s) begin
                        // The requester just served loses priority next time.
                        prio_r <= ready0_s;
                    end else begin
                        prio_r <= prio_r;
                    end
                end
                ST_CLEAR: begin
                    // clear_start is ignored here; a fill runs to completion.
                    if (fill_step_s) begin
                        if (fill_last_s) begin
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                            fill_cnt_r <= ADDR_ZERO;
                        end else begin
                            fill_cnt_r <= fill_cnt_r + ADDR_ONE;
                        end
                    end else begin
                        fill_cnt_r <= fill_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    fill_cnt_r <= ADDR_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered framebuffer write port
    // ------------------------------------------------------------------

    // Issue one-cycle write strobes; address/data hold between writes.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            wmemwe_r   <= 1'b0;
            wmemaddr_r <= ADDR_ZERO;
            wmemdata_r <= 3'd0;
        end else begin
            if (fill_step_s) begin
                wmemwe_r   <= 1'b1;
                wmemaddr_r <= fill_cnt_r;
                wmemdata_r <= fill_code_r;
            end else if (accept_s && in_range_s) begin
                wmemwe_r   <= 1'b1;
                wmemaddr_r <= sel_addr_s;
                wmemdata_r <= sel_data_s;
            end else begin
                wmemwe_r <= 1'b0;
            end
        end
    end

    assign wmemwe     = wmemwe_r;
    assign wmemaddr   = wmemaddr_r;
    assign wmemdata   = wmemdata_r;
    assign clear_busy = busy_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (FB_DEPTH reduced to 16).
// The vblank pause scenario is compiled in only when FB_VBLANK_GATE_EN is set.

module tb_fb_write_arbiter;

    localparam int DEPTH = 16;
    localparam int AW    = 16;

    logic          dclk = 1'b0;
    logic          clr;
    logic          vblank;
    logic          valid0, valid1;
    logic [AW-1:0] addr0, addr1;
    logic [2:0]    data0, data1;
    logic          ready0, ready1;
    logic          clear_start;
    logic [2:0]    clear_code;
    logic          clear_busy;
    logic [AW-1:0] wmemaddr;
    logic [2:0]    wmemdata;
    logic          wmemwe;

    int n_checks = 0;
    int n_fail   = 0;

    fb_write_arbiter #(.FB_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .dclk        (dclk),
        .clr         (clr),
        .vblank      (vblank),
        .valid0      (valid0),
        .valid1      (valid1),
        .addr0       (addr0),
        .addr1       (addr1),
        .data0       (data0),
        .data1       (data1),
        .ready0      (ready0),
        .ready1      (ready1),
        .clear_start (clear_start),
        .clear_code  (clear_code),
        .clear_busy  (clear_busy),
        .wmemaddr    (wmemaddr),
        .wmemdata    (wmemdata),
        .wmemwe      (wmemwe)
    );

    // 10 ns pixel clock
    always #5 dclk = ~dclk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge dclk);
        #1;
    endtask

    // Pulse clr inside one cycle, leaving inputs idle.
    task automatic do_reset;
        tick;
        valid0 = 1'b0; valid1 = 1'b0; clear_start = 1'b0;
        clr = 1'b1;
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b1; vblank = 1'b1;
        valid0 = 1'b1; valid1 = 1'b1;
        addr0 = 16'd1; addr1 = 16'd2; data0 = 3'd1; data1 = 3'd2;
        clear_start = 1'b0; clear_code = 3'd0;
        tick; tick;
        n_checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready0=%b ready1=%b expected 0 0", ready0, ready1);
        end
        n_checks++;
        if (wmemwe !== 1'b0 || wmemaddr !== 16'd0 || wmemdata !== 3'd0 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%0d busy=%b expected 0 0 0 0",
                     wmemwe, wmemaddr, wmemdata, clear_busy);
        end
        valid0 = 1'b0; valid1 = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_single_write;
        do_reset;
        valid0 = 1'b1; addr0 = 16'd5; data0 = 3'd3;
        #1;
        n_checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: ready0=%b ready1=%b expected 1 0", ready0, ready1);
        end
        tick;
        valid0 = 1'b0;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd5 || wmemdata !== 3'd3) begin
            n_fail++;
            $display("FAIL single_write: we=%b addr=%0d data=%0d expected 1 5 3", wmemwe, wmemaddr, wmemdata);
        end
        tick;
        n_checks++;
        if (wmemwe !== 1'b0 || wmemaddr !== 16'd5 || wmemdata !== 3'd3) begin
            n_fail++;
            $display("FAIL single_hold: we=%b addr=%0d data=%0d expected 0 5 3", wmemwe, wmemaddr, wmemdata);
        end
    endtask

    task automatic test_round_robin;
        logic          exp_r0;
        logic [AW-1:0] exp_a;
        logic [2:0]    exp_d;
        int            writes;
        do_reset;
        writes = 0;
        valid0 = 1'b1; valid1 = 1'b1;
        addr0 = 16'd10; data0 = 3'd1; addr1 = 16'd11; data1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            exp_r0 = ((i % 2) == 0);
            exp_a  = exp_r0 ? 16'd10 : 16'd11;
            exp_d  = exp_r0 ? 3'd1 : 3'd2;
            #1;
            n_checks++;
            if (ready0 !== exp_r0 || ready1 !== !exp_r0) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ready0=%b ready1=%b expected %b %b",
                         i, ready0, ready1, exp_r0, !exp_r0);
            end
            tick;
            if (wmemwe === 1'b1) writes++;
            n_checks++;
            if (wmemwe !== 1'b1 || wmemaddr !== exp_a || wmemdata !== exp_d) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: we=%b addr=%0d data=%0d expected 1 %0d %0d",
                         i, wmemwe, wmemaddr, wmemdata, exp_a, exp_d);
            end
        end
        valid0 = 1'b0; valid1 = 1'b0;
        tick;
        n_checks++;
        if (wmemwe !== 1'b0 || writes != 4) begin
            n_fail++;
            $display("FAIL rr_count: we=%b writes=%0d expected 0 4", wmemwe, writes);
        end
    endtask

    task automatic test_clear;
        logic exp_busy;
        do_reset;
        valid0 = 1'b1; addr0 = 16'd3; data0 = 3'd1;
        clear_start = 1'b1; clear_code = 3'd6;
        #1;
        n_checks++;
        if (ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start_wins: ready0=%b expected 0", ready0);
        end
        tick;
        clear_start = 1'b0; clear_code = 3'd2;
        #1;
        n_checks++;
        if (clear_busy !== 1'b1 || wmemwe !== 1'b0 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_enter: busy=%b we=%b ready0=%b expected 1 0 0", clear_busy, wmemwe, ready0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            tick;
            clear_start = 1'b0;
            #1;
            exp_busy = (k != DEPTH - 1);
            n_checks++;
            if (wmemwe !== 1'b1 || wmemaddr !== AW'(k) || wmemdata !== 3'd6 ||
                clear_busy !== exp_busy || ready0 !== !exp_busy) begin
                n_fail++;
                $display("FAIL clear_fill[%0d]: we=%b addr=%0d data=%0d busy=%b ready0=%b expected 1 %0d 6 %b %b",
                         k, wmemwe, wmemaddr, wmemdata, clear_busy, ready0, k, exp_busy, !exp_busy);
            end
            // A restart attempt mid-fill must be ignored.
            if (k == 5) begin
                clear_start = 1'b1; clear_code = 3'd1;
            end
        end
        tick;
        valid0 = 1'b0;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd3 || wmemdata !== 3'd1 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_after: we=%b addr=%0d data=%0d busy=%b expected 1 3 1 0",
                     wmemwe, wmemaddr, wmemdata, clear_busy);
        end
    endtask

    task automatic test_clr_mid_fill;
        int stray;
        do_reset;
        clear_start = 1'b1; clear_code = 3'd5;
        tick;
        clear_start = 1'b0;
        for (int k = 0; k <= 10; k++) tick;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd10 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: we=%b addr=%0d busy=%b expected 1 10 1", wmemwe, wmemaddr, clear_busy);
        end
        clr = 1'b1;
        #1;
        n_checks++;
        if (clear_busy !== 1'b0 || wmemwe !== 1'b0 || wmemaddr !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_now: busy=%b we=%b addr=%0d expected 0 0 0", clear_busy, wmemwe, wmemaddr);
        end
        clr = 1'b0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (wmemwe !== 1'b0 || clear_busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_no_resume: stray_cycles=%0d expected 0", stray);
        end
    endtask

    task automatic test_out_of_range;
        do_reset;
        valid1 = 1'b1; addr1 = AW'(DEPTH); data1 = 3'd5;
        #1;
        n_checks++;
        if (ready1 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_ready: ready1=%b ready0=%b expected 1 0", ready1, ready0);
        end
        tick;
        valid1 = 1'b0;
        n_checks++;
        if (wmemwe !== 1'b0 || wmemaddr !== 16'd0) begin
            n_fail++;
            $display("FAIL oor_write: we=%b addr=%0d expected 0 0", wmemwe, wmemaddr);
        end
    endtask

`ifdef FB_VBLANK_GATE_EN
    task automatic test_vblank_gate;
        int stray;
        do_reset;
        vblank = 1'b0; valid0 = 1'b1; addr0 = 16'd2; data0 = 3'd4;
        #1;
        n_checks++;
        if (ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_ready: ready0=%b expected 0", ready0);
        end
        valid0 = 1'b0; vblank = 1'b1;
        clear_start = 1'b1; clear_code = 3'd3;
        tick;
        clear_start = 1'b0;
        for (int k = 0; k <= 7; k++) tick;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd7) begin
            n_fail++;
            $display("FAIL gate_pre: we=%b addr=%0d expected 1 7", wmemwe, wmemaddr);
        end
        vblank = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (wmemwe !== 1'b0 || clear_busy !== 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL gate_pause: bad_cycles=%0d expected 0", stray);
        end
        vblank = 1'b1;
        tick;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd8 || wmemdata !== 3'd3) begin
            n_fail++;
            $display("FAIL gate_resume: we=%b addr=%0d data=%0d expected 1 8 3", wmemwe, wmemaddr, wmemdata);
        end
        do_reset;
    endtask
`else
    task automatic test_vblank_gate;
        do_reset;
        vblank = 1'b0; valid0 = 1'b1; addr0 = 16'd2; data0 = 3'd4;
        #1;
        n_checks++;
        if (ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL nogate_ready: ready0=%b expected 1", ready0);
        end
        tick;
        valid0 = 1'b0; vblank = 1'b1;
        n_checks++;
        if (wmemwe !== 1'b1 || wmemaddr !== 16'd2 || wmemdata !== 3'd4) begin
            n_fail++;
            $display("FAIL nogate_write: we=%b addr=%0d data=%0d expected 1 2 4", wmemwe, wmemaddr, wmemdata);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_round_robin;
        test_clear;
        test_clr_mid_fill;
        test_out_of_range;
        test_vblank_gate;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
